// File: rtl/lsu_pkg.sv
// lsu_pkg: MemOp encodings, sequencer state encoding and error codes shared by the LSU and DataMem.
package lsu_pkg;
    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_OP    = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;
endpackage

// File: rtl/lsu_align_chk.sv
// lsu_align_chk: decides whether a request is legal; an illegal op outranks misalignment.
module lsu_align_chk
    import lsu_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic       i_wr,
    input  logic [1:0] i_addr_lo,
    output logic       o_err,
    output logic [1:0] o_err_code
);
    logic w_illegal, w_misaligned, w_half;

    // unsigned variants only make sense for loads
    assign w_illegal    = (i_op == 3'b011) || (i_op[2:1] == 2'b11) || (i_wr && (i_op == MOP_BU || i_op == MOP_HU));
    assign w_half       = (i_op == MOP_H) || (i_op == MOP_HU);
    assign w_misaligned = (w_half && i_addr_lo[0]) || ((i_op == MOP_W) && (i_addr_lo != 2'b00));
    assign o_err        = w_illegal || w_misaligned;
    assign o_err_code   = w_illegal ? ERR_OP : (w_misaligned ? ERR_ALIGN : ERR_NONE);
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store sequencer between the execute stage and DataMem.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wr,
    input  logic [2:0]  i_req_op,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [1:0]  o_rsp_err_code,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [2:0]  o_mem_op,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wr, r_err;
    logic [2:0]       r_op;
    logic [1:0]       r_code;
    logic [31:0]      r_addr, r_wdata, r_rdata;
    logic             w_accept, w_err, w_last;
    logic [1:0]       w_code;

    lsu_align_chk u_chk (
        .i_op       (i_req_op),
        .i_wr       (i_req_wr),
        .i_addr_lo  (i_req_addr[1:0]),
        .o_err      (w_err),
        .o_err_code (w_code)
    );

    assign w_accept = i_req_valid && (r_state == S_IDLE);
    assign w_last   = (r_state == S_ACCESS) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = w_err ? S_RESP : S_ACCESS;
            S_ACCESS: if (w_last) w_next = S_RESP;
            S_RESP:   if (i_rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_op    <= MOP_W;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_code  <= ERR_NONE;
        end else if (w_accept) begin
            r_cnt   <= CNT_W'(MEM_LAT);
            r_wr    <= i_req_wr;
            r_op    <= i_req_op;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_rdata <= '0;
            r_err   <= w_err;
            r_code  <= w_code;
        end else if (w_last) begin
            if (!r_wr) r_rdata <= i_mem_rdata;
        end else if (r_state == S_ACCESS) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // strobes come straight from registered state so reset kills them immediately
    assign o_req_ready    = (r_state == S_IDLE);
    assign o_rsp_valid    = (r_state == S_RESP);
    assign o_rsp_rdata    = r_rdata;
    assign o_rsp_err      = r_err;
    assign o_rsp_err_code = r_code;
    assign o_mem_addr     = r_addr;
    assign o_mem_op       = r_op;
    assign o_mem_wdata    = r_wdata;
    assign o_mem_rd       = (r_state == S_ACCESS) && !r_wr;
    assign o_mem_wr       = w_last && r_wr;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench over three lsu_ctrl instances with MEM_LAT 0, 2 and 3.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst_n, req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_err, mem_rd, mem_wr;
    logic [2:0][2:0]  req_op, mem_op;
    logic [2:0][1:0]  rsp_code;
    logic [2:0][31:0] req_addr, req_wdata, rsp_rdata, mem_addr, mem_wdata, mem_rdata;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lsu_ctrl #(.MEM_LAT(g == 0 ? 0 : g + 1), .CNT_W(4)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n[g]),
            .i_req_valid    (req_valid[g]),
            .o_req_ready    (req_ready[g]),
            .i_req_wr       (req_wr[g]),
            .i_req_op       (req_op[g]),
            .i_req_addr     (req_addr[g]),
            .i_req_wdata    (req_wdata[g]),
            .o_rsp_valid    (rsp_valid[g]),
            .i_rsp_ready    (rsp_ready[g]),
            .o_rsp_rdata    (rsp_rdata[g]),
            .o_rsp_err      (rsp_err[g]),
            .o_rsp_err_code (rsp_code[g]),
            .o_mem_addr     (mem_addr[g]),
            .o_mem_rd       (mem_rd[g]),
            .o_mem_wr       (mem_wr[g]),
            .o_mem_op       (mem_op[g]),
            .o_mem_wdata    (mem_wdata[g]),
            .i_mem_rdata    (mem_rdata[g])
        );
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
        int          lat;
    } exp_t;

    typedef struct {
        int          lat, n_rd, n_wr, wr_at;
        bit          stable, hold_ok;
        logic [31:0] a1, wd1, rdata;
        logic [2:0]  op1;
        logic        err;
        logic [1:0]  code;
    } obs_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   lat_of[3] = '{0, 2, 3};

    function automatic logic [1:0] model_code(input logic wr, input logic [2:0] op, input logic [1:0] a);
        case (op)
            3'b000:  return 2'b00;
            3'b100:  return wr ? 2'b10 : 2'b00;
            3'b001:  return a[0] ? 2'b01 : 2'b00;
            3'b101:  return wr ? 2'b10 : (a[0] ? 2'b01 : 2'b00);
            3'b010:  return (a == 2'b00) ? 2'b00 : 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    // called on a negedge; returns on the first negedge after the accept edge
    task automatic send(input int d, input logic wr, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] load_val, output int waits);
        logic [1:0] c;
        c = model_code(wr, op, addr[1:0]);
        sb.push_back('{(c != 2'b00 || wr) ? 32'h0 : load_val, c != 2'b00, c, c != 2'b00 ? 1 : 2 + lat_of[d]});
        req_valid[d] = 1'b1; req_wr[d] = wr; req_op[d] = op; req_addr[d] = addr; req_wdata[d] = wdata;
        mem_rdata[d] = load_val;
        waits = 0;
        while (!req_ready[d] && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready[d]) begin
            checks++; errors++;
            $display("FAIL accept_timeout dut%0d req_ready=%b required 1", d, req_ready[d]);
        end
        @(negedge clk);
        req_valid[d] = 1'b0; req_wr[d] = ~wr; req_op[d] = 3'b111;
        req_addr[d] = $urandom; req_wdata[d] = $urandom;
    endtask

    task automatic collect(input int d, input int hold, output obs_t o);
        o = '{lat: 1, n_rd: 0, n_wr: 0, wr_at: 0, stable: 1'b1, hold_ok: 1'b1,
              a1: mem_addr[d], wd1: mem_wdata[d], rdata: 32'h0, op1: mem_op[d], err: 1'b0, code: 2'b00};
        rsp_ready[d] = 1'b0;
        while (!rsp_valid[d] && o.lat < 40) begin
            if (mem_rd[d]) o.n_rd++;
            if (mem_wr[d]) begin o.n_wr++; o.wr_at = o.lat; end
            if (mem_addr[d] !== o.a1) o.stable = 1'b0;
            @(negedge clk);
            o.lat++;
        end
        o.rdata = rsp_rdata[d]; o.err = rsp_err[d]; o.code = rsp_code[d];
        repeat (hold) begin
            @(negedge clk);
            if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== o.rdata || req_ready[d] !== 1'b0 || mem_rd[d] || mem_wr[d])
                o.hold_ok = 1'b0;
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({req_ready[d], rsp_valid[d], rsp_err[d], rsp_code[d], mem_rd[d], mem_wr[d], mem_op[d],
                 mem_addr[d], mem_wdata[d], rsp_rdata[d]} !==
                {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0}) begin
                errors++;
                $display("FAIL reset_values dut%0d got rdy=%b vld=%b err=%b code=%b rd=%b wr=%b op=%b addr=%h wd=%h rd=%h",
                         d, req_ready[d], rsp_valid[d], rsp_err[d], rsp_code[d], mem_rd[d], mem_wr[d], mem_op[d],
                         mem_addr[d], mem_wdata[d], rsp_rdata[d]);
            end
        end
    endtask

    task automatic test_load_lat0();
        obs_t o; exp_t e; int w;
        send(0, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, w);
        collect(0, 0, o);
        e = sb.pop_front();
        checks++;
        if (o.rdata !== e.rdata || o.err !== e.err || o.code !== e.code) begin
            errors++;
            $display("FAIL lw_lat0_rsp got %h/%b/%b required %h/%b/%b", o.rdata, o.err, o.code, e.rdata, e.err, e.code);
        end
        checks++;
        if (o.lat !== e.lat) begin errors++; $display("FAIL lw_lat0_latency got %0d required %0d", o.lat, e.lat); end
        checks++;
        if (o.n_rd !== 1 || o.n_wr !== 0) begin
            errors++; $display("FAIL lw_lat0_strobes got rd=%0d wr=%0d required rd=1 wr=0", o.n_rd, o.n_wr);
        end
    endtask

    task automatic test_store_lat2();
        obs_t o; exp_t e; int w;
        send(1, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h1234_5678, w);
        collect(1, 0, o);
        e = sb.pop_front();
        checks++;
        if (o.n_wr !== 1 || o.wr_at !== 3 || o.n_rd !== 0) begin
            errors++;
            $display("FAIL sb_lat2_strobes got wr=%0d at %0d rd=%0d required wr=1 at 3 rd=0", o.n_wr, o.wr_at, o.n_rd);
        end
        checks++;
        if (o.op1 !== 3'b000 || o.a1 !== 32'h8000_0003 || o.wd1 !== 32'h0000_00A5 || !o.stable) begin
            errors++;
            $display("FAIL sb_lat2_bus got op=%b addr=%h wd=%h stable=%b required 000 80000003 000000a5 1",
                     o.op1, o.a1, o.wd1, o.stable);
        end
        checks++;
        if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
            errors++;
            $display("FAIL sb_lat2_rsp got lat=%0d rdata=%h err=%b required %0d %h %b", o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
        end
    endtask

    task automatic test_errors();
        logic [2:0] ops[6] = '{3'b001, 3'b100, 3'b011, 3'b010, 3'b101, 3'b110};
        logic       wrs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] adr[6] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0001, 32'h8000_0002, 32'h8000_0003, 32'h8000_0000};
        obs_t o; exp_t e; int w;
        for (int i = 0; i < 6; i++) begin
            send(i % 2, wrs[i], ops[i], adr[i], 32'hFFFF_FFFF, 32'hCAFE_F00D, w);
            collect(i % 2, 0, o);
            e = sb.pop_front();
            checks++;
            if (o.err !== e.err || o.code !== e.code || o.rdata !== e.rdata || o.lat !== e.lat) begin
                errors++;
                $display("FAIL err_case%0d got err=%b code=%b rdata=%h lat=%0d required %b %b %h %0d",
                         i, o.err, o.code, o.rdata, o.lat, e.err, e.code, e.rdata, e.lat);
            end
            checks++;
            if (o.n_rd !== 0 || o.n_wr !== 0) begin
                errors++; $display("FAIL err_case%0d_strobes got rd=%0d wr=%0d required 0 0", i, o.n_rd, o.n_wr);
            end
        end
    endtask

    task automatic test_legal_mix();
        logic [2:0] ops[5] = '{3'b001, 3'b000, 3'b101, 3'b100, 3'b010};
        logic       wrs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] adr[5] = '{32'h8000_0002, 32'h8000_0007, 32'h8000_0006, 32'h8000_0001, 32'h8000_0004};
        obs_t o; exp_t e; int w;
        for (int i = 0; i < 5; i++) begin
            send(1, wrs[i], ops[i], adr[i], $urandom, $urandom, w);
            collect(1, 0, o);
            e = sb.pop_front();
            checks++;
            if (o.err !== e.err || o.code !== e.code || o.rdata !== e.rdata || o.lat !== e.lat ||
                o.n_wr !== 32'(wrs[i]) || o.n_rd !== (wrs[i] ? 0 : 3)) begin
                errors++;
                $display("FAIL legal_case%0d got err=%b code=%b rdata=%h lat=%0d rd=%0d wr=%0d required %b %b %h %0d",
                         i, o.err, o.code, o.rdata, o.lat, o.n_rd, o.n_wr, e.err, e.code, e.rdata, e.lat);
            end
        end
    endtask

    task automatic test_backpressure();
        obs_t o; exp_t e; int w;
        send(0, 1'b0, 3'b100, 32'h8000_0005, 32'h0, 32'h0000_00A5, w);
        collect(0, 5, o);
        e = sb.pop_front();
        checks++;
        if (!o.hold_ok || o.rdata !== e.rdata) begin
            errors++; $display("FAIL bp_hold got hold_ok=%b rdata=%h required 1 %h", o.hold_ok, o.rdata, e.rdata);
        end
        checks++;
        if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_idle_ready got %b required 1", req_ready[0]); end
        send(0, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'h0BAD_CAFE, w);
        checks++;
        if (w !== 0) begin errors++; $display("FAIL bp_reaccept_wait got %0d required 0", w); end
        collect(0, 0, o);
        e = sb.pop_front();
        checks++;
        if (o.rdata !== e.rdata || o.lat !== e.lat) begin
            errors++; $display("FAIL bp_next_rsp got %h lat=%0d required %h %0d", o.rdata, o.lat, e.rdata, e.lat);
        end
    endtask

    task automatic test_reset_mid_access();
        obs_t o; exp_t e; int w; int n_wr;
        send(2, 1'b1, 3'b010, 32'h8000_0020, 32'h5555_AAAA, 32'h0, w);
        void'(sb.pop_back());
        n_wr = mem_wr[2] ? 1 : 0;
        @(negedge clk);
        if (mem_wr[2]) n_wr++;
        rst_n[2] = 1'b0;
        #1;
        checks++;
        if ({req_ready[2], rsp_valid[2], mem_rd[2], mem_wr[2], mem_op[2], mem_addr[2], mem_wdata[2]} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL midrst_values got rdy=%b vld=%b rd=%b wr=%b op=%b addr=%h wd=%h required 1 0 0 0 010 0 0",
                     req_ready[2], rsp_valid[2], mem_rd[2], mem_wr[2], mem_op[2], mem_addr[2], mem_wdata[2]);
        end
        repeat (3) begin
            @(negedge clk);
            if (mem_wr[2]) n_wr++;
        end
        rst_n[2] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_wr[2]) n_wr++;
        end
        checks++;
        if (n_wr !== 0 || rsp_valid[2] !== 1'b0) begin
            errors++; $display("FAIL midrst_no_write got writes=%0d rsp_valid=%b required 0 0", n_wr, rsp_valid[2]);
        end
        send(2, 1'b0, 3'b010, 32'h8000_0024, 32'h0, 32'h7777_1111, w);
        collect(2, 0, o);
        e = sb.pop_front();
        checks++;
        if (o.rdata !== e.rdata || o.lat !== e.lat || o.err !== 1'b0 || o.n_rd !== 4) begin
            errors++;
            $display("FAIL midrst_next_lw got %h lat=%0d err=%b rd=%0d required %h %0d 0 4", o.rdata, o.lat, o.err, o.n_rd, e.rdata, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o; exp_t e; int w;
        for (int i = 0; i < 4; i++) begin
            send(2, 1'b0, (i % 2) ? 3'b010 : 3'b101, 32'h8000_0100 + 32'(i * 4), 32'h0, $urandom, w);
            collect(2, 0, o);
            e = sb.pop_front();
            checks++;
            if (o.rdata !== e.rdata || o.lat !== e.lat || w !== 0) begin
                errors++;
                $display("FAIL b2b_%0d got %h lat=%0d waits=%0d required %h %0d 0", i, o.rdata, o.lat, w, e.rdata, e.lat);
            end
        end
    endtask

    initial begin
        rst_n = '0; req_valid = '0; req_wr = '0; req_op = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = '1;
        @(negedge clk);
        test_load_lat0();
        test_store_lat2();
        test_errors();
        test_legal_mix();
        test_backpressure();
        test_reset_mid_access();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
